mul_rep_add: RTL and testbench
==============================

# mul_rep_add

Unsigned sequential multiplier using repeated addition: the multiplicand A is added into the product register P once per cycle while counter B counts the multiplier down to zero. The block pairs a datapath (registers A, B, P, an adder, a decrementer and a zero detector) with a Moore FSM controller. Operands arrive serially on a shared `data_in` bus, and a level `start` / `done` handshake connects the block to its host.

## Interface
- `WIDTH`, default 16: width of `data_in`, A, B and the product.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: level request to begin a multiplication.
- `data_in`  in  WIDTH: operand bus; carries A during LOAD_A and B during LOAD_B.
- `done`  out  1: high while the FSM is in DONE.
- `y`  out  WIDTH: product register P, read directly.
- `ovf`  out  1: sticky overflow flag; present only with `MUL_OVF_EN`.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- IDLE: if `start`=1, go to LOAD_A; otherwise stay.
- LOAD_A: A <= `data_in`; go to LOAD_B.
- LOAD_B: B <= `data_in`; P <= 0; go to ADD.
- ADD, B != 0: P <= P + A; B <= B - 1; stay in ADD.
- ADD, B == 0: A, B and P hold; go to DONE.
- DONE: `done`=1. Stay while `start`=1; go to IDLE when `start`=0.
- Arithmetic: unsigned. P wraps modulo 2^WIDTH; the carry-out is discarded unless `MUL_OVF_EN` is defined.
- Zero detection: `eqz` = (B == 0) is combinational from the B register.
- Outputs: `done` is Moore, decoded from state only. `y` continuously shows P. Intermediate P values are visible during ADD.
- `start` is ignored in every state except IDLE and DONE.
- Reset (`rst_n`=0 at a rising edge):
  - state <= IDLE; A, B, P <= 0; `done`=0; `ovf`=0.
  - This applies in every state, including mid-operation; the operation in progress is abandoned.
- Boundary cases:
  - B=0: P stays 0 and the block reaches DONE after one ADD cycle.
  - A=0: the FSM still runs B add cycles and the result is 0.

## Timing
- Edge 1 (`start` sampled in IDLE): enter LOAD_A.
- Edge 2: capture A.
- Edge 3: capture B and clear P.
- Edges 4 through 3+B: one addition per edge.
- Edge 4+B: enter DONE.
- `done` rises 4+B cycles after the edge that samples `start`; B=5 gives 9 cycles.
- The host must hold A on `data_in` across edge 2 and B across edge 3.
- Back-to-back operation: with `start` held high, the block stays in DONE. The host drops `start` for at least one cycle (DONE to IDLE), then raises it again.

## Configuration
- `MUL_OVF_EN` defined:
  - Adds the `ovf` output and an ovf register.
  - LOAD_B clears ovf.
  - ovf sets on any ADD-cycle carry-out of P + A and stays set until the next LOAD_B or reset.
- `MUL_OVF_EN` undefined: no `ovf` port and no ovf register. All other behaviour is identical.

## Structure
- Shared package `mul_rep_add_pkg` holds:
  - the state enum `mul_state_t` (IDLE, LOAD_A, LOAD_B, ADD, DONE);
  - the default WIDTH constant.
- Sub-module `mul_rep_add_dp` is the datapath:
  - registers A, B, P and the adder, decrementer and zero detector;
  - control inputs lda, ldb, ldp, clrp, decb; status output eqz.
- The FSM lives in the `mul_rep_add` top, which drives those control strobes.

## Test plan
- Reset, then `start`=1 with A=17, B=5: `y`=85 and `done`=1 exactly 9 cycles after `start` is sampled. `y` then holds 85 while `start` stays high.
- A=9, B=0: `y`=0 and `done` rises after 4 cycles.
- A=0, B=7: `y`=0 and `done` rises after 11 cycles. `y` stays 0 on every ADD cycle.
- A=16'hFFFF, B=2: `y`=16'hFFFE. With `MUL_OVF_EN`, `ovf`=1; without it, there is no `ovf` port.
- Reset mid-ADD with A=3, B=10, asserting `rst_n`=0 after 4 adds: next cycle shows state IDLE, `y`=0, `done`=0. Re-run with A=4, B=4 gives `y`=16.
- Back-to-back: after DONE, drop `start` for 1 cycle, then run A=6, B=7: `y`=42. A `start` toggle during ADD changes nothing.

Source files
------------

// File: rtl/mul_rep_add_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
package mul_rep_add_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } mul_state_t;

endpackage

// File: rtl/mul_rep_add_if.sv
// Host-side bus of the multiplier: start/done handshake, operand bus, product.
// Optional feature macro: MUL_OVF_EN adds the sticky overflow flag.
interface mul_rep_add_if
    import mul_rep_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [WIDTH-1:0] y;
`ifdef MUL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start,
        output data_in,
        input  done,
`ifdef MUL_OVF_EN
        input  ovf,
`endif
        input  y
    );

    modport slave (
        input  start,
        input  data_in,
        output done,
`ifdef MUL_OVF_EN
        output ovf,
`endif
        output y
    );

endinterface

// File: rtl/mul_rep_add_dp.sv
// Datapath: operand registers A and B, product register P, adder,
// decrementer and zero detector. Sequenced entirely by the controller strobes.
// Optional feature macro: MUL_OVF_EN adds a sticky carry-out register.
module mul_rep_add_dp
    import mul_rep_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lda,
    input  logic             ldb,
    input  logic             ldp,
    input  logic             clrp,
    input  logic             decb,
    input  logic [WIDTH-1:0] data_in,
    output logic             eqz,
`ifdef MUL_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
`ifdef MUL_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;
`else
    logic [WIDTH-1:0] sum;
`endif

    // Next-state of the datapath registers from the control strobes.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
`ifdef MUL_OVF_EN
        ovf_d = ovf_q;
        sum   = {1'b0, p_q} + {1'b0, a_q};
`else
        sum   = p_q + a_q;
`endif
        if (lda) begin
            a_d = data_in;
        end
        if (ldb) begin
            b_d = data_in;
        end else if (decb) begin
            b_d = b_q - WIDTH'(1);
        end
        if (clrp) begin
            p_d = '0;
`ifdef MUL_OVF_EN
            ovf_d = 1'b0;
`endif
        end else if (ldp) begin
            p_d = sum[WIDTH-1:0];
`ifdef MUL_OVF_EN
            if (sum[WIDTH]) begin
                ovf_d = 1'b1;
            end
`endif
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
`ifdef MUL_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
`ifdef MUL_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    // Zero detect is combinational so ADD can decide in the same cycle.
    assign eqz = (b_q == '0);
    assign p   = p_q;
`ifdef MUL_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule

// File: rtl/mul_rep_add.sv
// Unsigned repeated-addition multiplier: Moore FSM controller driving the
// datapath in mul_rep_add_dp. Operands arrive serially on data_in.
// Optional feature macro: MUL_OVF_EN adds the sticky ovf output.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// LOAD_A | capture multiplicand A from data_in
// LOAD_B | capture multiplier B from data_in, clear P (and ovf)
// ADD    | P += A, B -= 1 each cycle until B reaches zero
// DONE   | done high; held until the host drops start
module mul_rep_add
    import mul_rep_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_rep_add_if.slave bus
);

    mul_state_t state_q, state_d;
    logic       lda, ldb, ldp, clrp, decb;
    logic       eqz;

    mul_rep_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .lda     (lda),
        .ldb     (ldb),
        .ldp     (ldp),
        .clrp    (clrp),
        .decb    (decb),
        .data_in (bus.data_in),
        .eqz     (eqz),
`ifdef MUL_OVF_EN
        .ovf     (bus.ovf),
`endif
        .p       (bus.y)
    );

    // Next-state and datapath strobes; start only matters in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        lda     = 1'b0;
        ldb     = 1'b0;
        ldp     = 1'b0;
        clrp    = 1'b0;
        decb    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                lda     = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ldb     = 1'b1;
                clrp    = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                if (eqz) begin
                    state_d = DONE;
                end else begin
                    ldp  = 1'b1;
                    decb = 1'b1;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mul_rep_add.sv
module tb_mul_rep_add;
    import mul_rep_add_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        int          cyc;
        bit          ovf;
        bit          tog;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    vec_t sb_q[$];
    vec_t vecs[7];

    mul_rep_add_if #(.WIDTH(16)) bus ();

    mul_rep_add #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drives start and both operands; returns after the edge that loads B.
    task automatic start_load(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.data_in = a;
        @(posedge clk); #1;
        bus.data_in = b;
        @(posedge clk); #1;
        bus.data_in = 16'hDEAD;
        chk("p_cleared", 32'(bus.y), 32'd0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit tog);
        int          cnt;
        logic [15:0] step;
        vec_t        e;
        start_load(a, b);
        cnt = 3;
        while (bus.done !== 1'b1 && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (tog && cnt == 5) bus.start = 1'b0;
            if (tog && cnt == 6) bus.start = 1'b1;
            if (bus.done !== 1'b1 && cnt <= 3 + int'(b)) begin
                step = 16'(int'(a) * (cnt - 3));
                chk("add_step", 32'(bus.y), 32'(step));
            end
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("done_cycles", 32'(cnt), 32'(e.cyc));
        chk("product", 32'(bus.y), 32'(e.y));
`ifdef MUL_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        repeat (2) begin
            @(posedge clk); #1;
            chk("done_hold", 32'(bus.done), 32'd1);
            chk("y_hold", 32'(bus.y), 32'(e.y));
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", 32'(bus.done), 32'd0);
        chk("y_idle", 32'(bus.y), 32'(e.y));
    endtask

    initial begin
        vecs[0] = '{a: 16'd17,    b: 16'd5,   y: 16'd85,    cyc: 9,   ovf: 1'b0, tog: 1'b0};
        vecs[1] = '{a: 16'd9,     b: 16'd0,   y: 16'd0,     cyc: 4,   ovf: 1'b0, tog: 1'b0};
        vecs[2] = '{a: 16'd0,     b: 16'd7,   y: 16'd0,     cyc: 11,  ovf: 1'b0, tog: 1'b0};
        vecs[3] = '{a: 16'hFFFF,  b: 16'd2,   y: 16'hFFFE,  cyc: 6,   ovf: 1'b1, tog: 1'b0};
        vecs[4] = '{a: 16'd6,     b: 16'd7,   y: 16'd42,    cyc: 11,  ovf: 1'b0, tog: 1'b1};
        vecs[5] = '{a: 16'd300,   b: 16'd300, y: 16'd24464, cyc: 304, ovf: 1'b1, tog: 1'b0};
        vecs[6] = '{a: 16'd1,     b: 16'd1,   y: 16'd1,     cyc: 5,   ovf: 1'b0, tog: 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.data_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef MUL_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sb_q.push_back(vecs[i]);
            run_op(vecs[i].a, vecs[i].b, vecs[i].tog);
        end

        // Reset in the middle of ADD after four additions.
        start_load(16'd3, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_y", 32'(bus.y), 32'd12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_y", 32'(bus.y), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        sb_q.push_back('{a: 16'd4, b: 16'd4, y: 16'd16, cyc: 8, ovf: 1'b0, tog: 1'b0});
        run_op(16'd4, 16'd4, 1'b0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
